div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
// - Multi-cycle 32/32 radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// - Produces {HI=remainder, LO=quotient} for the HI/LO write path.
// - Drives stall_div, the stall_divE input to the hazard unit, which holds F/D/E while a divide runs.
// PARAMETERS
// - WIDTH  32  operand width; quotient and remainder are WIDTH bits each; counter is clog2(WIDTH)+1 bits
// PORTS
// - clk         in   1     clock; one clock domain
// - rst         in   1     reset, synchronous, active-high
// - start       in   1     DIV/DIVU in E stage; held high by E stall until ready
// - signed_div  in   1     1=DIV (two's complement), 0=DIVU; sampled with start in IDLE
// - opa         in   32    dividend (rs); latched on accept
// - opb         in   32    divisor (rt); latched on accept
// - annul       in   1     cancel (flush/exception); highest priority after rst
// - result      out  64    [63:32]=remainder (HI), [31:0]=quotient (LO); valid when ready=1
// - ready       out  1     one-cycle pulse, result valid
// - stall_div   out  1     combinational: start & ~ready & ~annul
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, result=0, ready=0, internal regs=0. A reset mid-operation aborts it with no ready.
// - FSM states:
//   - IDLE: if start & ~annul & opb!=0, latch |opa|, |opb|, signs, mode; go ON with cnt=0.
//     If start & ~annul & opb==0, go DZ.
//   - ON: each cycle shift {rem,quo} left 1 and trial-subtract divisor from the upper bits.
//     If non-negative, keep the difference and set quo LSB=1.
//     cnt++ each cycle; after 32 iterations (cnt==31 processed) go END.
//   - DZ: one cycle; set quotient=32'hFFFF_FFFF, remainder=latched opa (raw, unsigned); go END.
//   - END: ready=1 for exactly this cycle; result registered and stable; go IDLE unconditionally.
// - Latency: accept at cycle T (IDLE & start); ready=1 at T+33 (normal) or T+2 (divide by zero).
//   stall_div is high from T through T+32 and low at T+33, so the pipeline advances on the ready cycle.
// - Back-to-back: if start is still high in IDLE after END (the next instruction is a divide),
//   accept a new operation. The old operation is never re-run because END always exits.
// - Signed fix-up, applied on the ON->END transition:
//   - quotient negated if opa[31]^opb[31];
//   - remainder negated if opa[31] (remainder takes the dividend's sign).
// - Signed 0x8000_0000 / 0xFFFF_FFFF: |a| = 0x8000_0000 unsigned.
//   Quotient = 0x8000_0000 after negation, remainder = 0. No trap.
// - annul: in any non-IDLE state, return to IDLE next cycle; ready stays 0; result unchanged.
//   In IDLE, annul blocks acceptance.
// - Operand changes after acceptance are ignored. start dropping mid-op without annul does not abort.
// - result holds its last value in all states except END update; ready=0 outside END.
// TESTING
// - rst 2 cycles, then idle -> result=0, ready=0, stall_div=0 every cycle.
// - DIVU 100/7, start held -> stall_div=1 for 33 cycles; ready at T+33.
//   result={32'd2, 32'd14}; stall_div=0 in the same cycle.
// - DIV -7/2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIV 7/-2 -> LO=32'hFFFF_FFFD, HI=32'd1.
// - DIVU 5/0 -> ready at T+2, result={32'd5, 32'hFFFF_FFFF}.
//   DIV 0x8000_0000/0xFFFF_FFFF -> ready at T+33, LO=0x8000_0000, HI=0.
// - Annul at T+10 -> IDLE at T+11, no ready pulse, result unchanged.
//   A new start at T+12 gives ready at T+45. Repeat with rst at T+10 -> same, with result=0.
// - Two DIVUs back to back, start high continuously (20/3, then 9/4) -> ready at T+33 with {2,6}.
//   Second op accepted at T+34, ready at T+67 with {1,2}.

Source files
------------

// File: rtl/div_if.sv
// Handshake bundle between the execute stage and the multi-cycle divider.
interface div_if #(parameter int WIDTH = 32);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 stall_div;

    modport master (output start, signed_div, opa, opb, annul,
                    input  result, ready, stall_div);
    modport slave  (input  start, signed_div, opa, opb, annul,
                    output result, ready, stall_div);
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: {HI=remainder, LO=quotient}.
// Runs on operand magnitudes; signs are reapplied when the last iteration retires.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  io
);
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_DZ, S_END} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]       rem_sh, diff;
    logic                 ge;
    logic [WIDTH-1:0]     rem_nx, quo_nx, abs_a, abs_b;

    // Partial remainder needs one extra bit: (rem<<1)|bit can reach 2*divisor-1.
    always_comb begin
        rem_sh = {rem_q, quo_q[MSB]};
        ge     = rem_sh >= {1'b0, div_q};
        diff   = rem_sh - {1'b0, div_q};
        rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ge};
        abs_a  = (io.signed_div && io.opa[MSB]) ? -io.opa : io.opa;
        abs_b  = (io.signed_div && io.opb[MSB]) ? -io.opb : io.opb;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (io.annul && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.start && !io.annul) begin
                        cnt_d = '0;
                        rem_d = '0;
                        if (io.opb != '0) begin
                            state_d   = S_ON;
                            quo_d     = abs_a;
                            div_d     = abs_b;
                            neg_quo_d = io.signed_div & (io.opa[MSB] ^ io.opb[MSB]);
                            neg_rem_d = io.signed_div & io.opa[MSB];
                        end else begin
                            // Divide by zero keeps the raw dividend as the remainder.
                            state_d   = S_DZ;
                            quo_d     = io.opa;
                            div_d     = '0;
                            neg_quo_d = 1'b0;
                            neg_rem_d = 1'b0;
                        end
                    end
                end
                S_ON: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_END;
                        result_d = {neg_rem_q ? -rem_nx : rem_nx,
                                    neg_quo_q ? -quo_nx : quo_nx};
                    end
                end
                S_DZ: begin
                    state_d  = S_END;
                    result_d = {quo_q, {WIDTH{1'b1}}};
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign io.result    = result_q;
    assign io.ready     = (state_q == S_END) && !io.annul;
    assign io.stall_div = io.start & ~io.ready & ~io.annul;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    logic [63:0] last_exp = 64'd0;

    div_if #(.WIDTH(32)) dif ();
    div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .io(dif));

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Drives one operation from an IDLE cycle; reports latency, result and stall errors.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit hold,
                          output int lat, output logic [63:0] res, output int stall_bad);
        lat = -1; res = 64'd0; stall_bad = 0;
        dif.start = 1'b1; dif.opa = a; dif.opb = b; dif.signed_div = sgn;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dif.ready === 1'b1) begin
                lat = k; res = dif.result;
                if (dif.stall_div !== 1'b0) stall_bad++;
                break;
            end
            if (dif.stall_div !== 1'b1) stall_bad++;
            @(posedge clk); #1;
            if (k == 0) begin
                dif.opa = $urandom; dif.opb = $urandom; dif.signed_div = 1'($urandom);
            end
        end
        @(posedge clk); #1;
        if (!hold || lat < 0) dif.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (dif.result !== 64'd0 || dif.ready !== 1'b0 || dif.stall_div !== 1'b0)
                $display("FAIL reset_idle cyc%0d: result=%h ready=%b stall=%b, want 0/0/0",
                         k, dif.result, dif.ready, dif.stall_div);
            else passed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic;
        int lat, sb; logic [63:0] res;
        run_op(32'd100, 32'd7, 1'b0, 1'b0, lat, res, sb);
        checks++;
        if (lat !== 33) $display("FAIL divu_latency: got %0d want 33", lat); else passed++;
        checks++;
        if (res !== {32'd2, 32'd14}) $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14});
        else passed++;
        checks++;
        if (sb !== 0) $display("FAIL divu_stall: %0d bad stall cycles, want 0", sb); else passed++;
        last_exp = {32'd2, 32'd14};
    endtask

    task automatic test_signed;
        int lat, sb; logic [63:0] res;
        run_op(-32'sd7, 32'd2, 1'b1, 1'b0, lat, res, sb);
        checks++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat !== 33)
            $display("FAIL div_m7_2: got %h lat %0d want ffffffff_fffffffd lat 33", res, lat);
        else passed++;
        run_op(32'd7, -32'sd2, 1'b1, 1'b0, lat, res, sb);
        checks++;
        if (res !== {32'd1, 32'hFFFF_FFFD} || lat !== 33)
            $display("FAIL div_7_m2: got %h lat %0d want 00000001_fffffffd lat 33", res, lat);
        else passed++;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, res, sb);
        checks++;
        if (res !== {32'd0, 32'h8000_0000} || lat !== 33)
            $display("FAIL div_overflow: got %h lat %0d want 00000000_80000000 lat 33", res, lat);
        else passed++;
        last_exp = {32'd0, 32'h8000_0000};
    endtask

    task automatic test_div_zero;
        int lat, sb; logic [63:0] res;
        run_op(32'd5, 32'd0, 1'b0, 1'b0, lat, res, sb);
        checks++;
        if (lat !== 2) $display("FAIL dz_latency: got %0d want 2", lat); else passed++;
        checks++;
        if (res !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL dz_5_0: got %h want 00000005_ffffffff", res);
        else passed++;
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0, lat, res, sb);
        checks++;
        if (res !== {32'hFFFF_FFF0, 32'hFFFF_FFFF} || lat !== 2 || sb !== 0)
            $display("FAIL dz_signed: got %h lat %0d stall_bad %0d want fffffff0_ffffffff lat 2", res, lat, sb);
        else passed++;
        last_exp = {32'hFFFF_FFF0, 32'hFFFF_FFFF};
    endtask

    // Abort at T+10 via annul (use_rst=0) or reset (use_rst=1); restart at T+12.
    task automatic test_abort(input bit use_rst);
        int pulses, lat, sb; logic [63:0] res, want_res;
        string nm;
        nm = use_rst ? "rst_mid" : "annul";
        want_res = use_rst ? 64'd0 : last_exp;
        pulses = 0;
        dif.start = 1'b1; dif.opa = 32'd1000; dif.opb = 32'd3; dif.signed_div = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); if (dif.ready === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        dif.start = 1'b0;
        if (use_rst) rst = 1'b1; else dif.annul = 1'b1;
        @(negedge clk);
        if (dif.ready === 1'b1) pulses++;
        checks++;
        if (dif.stall_div !== 1'b0) $display("FAIL %s_stall: got %b want 0", nm, dif.stall_div);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0; dif.annul = 1'b0;
        @(negedge clk);
        if (dif.ready === 1'b1) pulses++;
        checks++;
        if (dif.result !== want_res) $display("FAIL %s_result: got %h want %h", nm, dif.result, want_res);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (pulses !== 0) $display("FAIL %s_no_ready: got %0d pulses want 0", nm, pulses); else passed++;
        run_op(32'd50, 32'd5, 1'b0, 1'b0, lat, res, sb);
        checks++;
        if (lat !== 33 || res !== {32'd0, 32'd10})
            $display("FAIL %s_restart: got %h lat %0d want 00000000_0000000a lat 33", nm, res, lat);
        else passed++;
        last_exp = {32'd0, 32'd10};
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, sb1, sb2; logic [63:0] r1, r2;
        run_op(32'd20, 32'd3, 1'b0, 1'b1, lat1, r1, sb1);
        run_op(32'd9, 32'd4, 1'b0, 1'b0, lat2, r2, sb2);
        checks++;
        if (lat1 !== 33 || r1 !== {32'd2, 32'd6})
            $display("FAIL b2b_first: got %h lat %0d want 00000002_00000006 lat 33", r1, lat1);
        else passed++;
        checks++;
        if (lat2 !== 33 || r2 !== {32'd1, 32'd2} || sb2 !== 0)
            $display("FAIL b2b_second: got %h lat %0d stall_bad %0d want 00000001_00000002 lat 33", r2, lat2, sb2);
        else passed++;
        last_exp = {32'd1, 32'd2};
    endtask

    task automatic test_random;
        int lat, sb, want_lat; logic [63:0] res, want;
        logic [31:0] a, b; bit sgn;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom; sgn = 1'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: a = 32'h8000_0000;
                default: ;
            endcase
            want = model(a, b, sgn);
            want_lat = (b == 32'd0) ? 2 : 33;
            run_op(a, b, sgn, 1'b0, lat, res, sb);
            checks++;
            if (res !== want || lat !== want_lat || sb !== 0)
                $display("FAIL rand%0d %h/%h s=%0d: got %h lat %0d stall_bad %0d want %h lat %0d",
                         i, a, b, sgn, res, lat, sb, want, want_lat);
            else passed++;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        dif.start = 1'b0; dif.signed_div = 1'b0; dif.opa = '0; dif.opb = '0; dif.annul = 1'b0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
